// File: rtl/dsd_cnt_pkg.sv
// Shared definitions for the dsd counter family (up and down counters).
// Contents: default counter width, all-ones helper, default-width count type.
package dsd_cnt_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 4;

  // Default-width count value.
  typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

  // Largest value representable in 'width' bits (2^width - 1).
  function automatic logic [31:0] cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage : dsd_cnt_pkg

// File: rtl/bin_down_counter.sv
// WIDTH-bit synchronous binary down counter with enable, parallel load,
// combinational zero flag and a one-cycle registered borrow on underflow.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (count <= INIT, borrow <= 0)
//   en     in   decrement enable
//   load   in   parallel load strobe (priority over en)
//   din    in   WIDTH-bit load value
//   count  out  registered counter value
//   zero   out  combinational, count == 0
//   borrow out  registered, high for one cycle after an underflow
//
// Build option: define DOWNCNT_RELOAD_EN to add a reload register written by
// every load; underflow then restarts from the reload value instead of
// all ones, giving a programmable modulus of reload+1.
module bin_down_counter
  import dsd_cnt_pkg::*;
#(
  parameter int unsigned       WIDTH = CNT_WIDTH_DEF,
  parameter logic [WIDTH-1:0]  INIT  = WIDTH'(cnt_max(WIDTH))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] CNT_ALL_ONES = WIDTH'(cnt_max(WIDTH));

  logic [WIDTH-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] wrap_val;

`ifdef DOWNCNT_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  // Underflow restarts from the last loaded value.
  assign wrap_val = reload_q;
`else
  assign wrap_val = CNT_ALL_ONES;
`endif

  // Next-state: load > decrement/underflow > hold; borrow only on underflow.
  always_comb begin
    count_d  = count_q;
    borrow_d = 1'b0;
`ifdef DOWNCNT_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d  = din;
`ifdef DOWNCNT_RELOAD_EN
      reload_d = din;
`endif
    end else if (en) begin
      if (count_q == '0) begin
        count_d  = wrap_val;
        borrow_d = 1'b1;
      end else begin
        count_d  = count_q - WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= INIT;
      borrow_q <= 1'b0;
`ifdef DOWNCNT_RELOAD_EN
      reload_q <= INIT;
`endif
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
`ifdef DOWNCNT_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count  = count_q;
  assign borrow = borrow_q;
  assign zero   = (count_q == '0);

endmodule : bin_down_counter

// File: tb/tb_bin_down_counter.sv
// Scoreboard bench for bin_down_counter: a driver issues one directed vector
// per cycle and queues the hand-derived expected response; a monitor pops and
// compares after each rising edge. A second instance chained on borrow
// checks the cascade behaviour.
module tb_bin_down_counter;

  typedef struct packed {
    logic [3:0] cnt;
    logic       zero;
    logic       borrow;
    logic [3:0] up_cnt;
    logic       up_zero;
    logic       up_borrow;
  } exp_t;

`ifdef DOWNCNT_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] count;
  logic       zero;
  logic       borrow;
  logic [3:0] up_count;
  logic       up_zero;
  logic       up_borrow;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [3:0] exp_up = 4'd15;
  logic       prev_b = 1'b0;

  always #5 clk = ~clk;

  bin_down_counter dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
    .count(count), .zero(zero), .borrow(borrow)
  );

  // Upper stage: decrements once per lower-stage underflow.
  bin_down_counter up (
    .clk(clk), .reset(reset), .en(borrow), .load(1'b0), .din(4'd0),
    .count(up_count), .zero(up_zero), .borrow(up_borrow)
  );

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic step(input logic r, input logic l, input logic e,
                      input logic [3:0] d, input logic [3:0] ec, input logic eb);
    exp_t x;
    @(negedge clk);
    reset = r; load = l; en = e; din = d;
    if (r)           exp_up = 4'd15;
    else if (prev_b) exp_up = exp_up - 4'd1;
    prev_b = r ? 1'b0 : eb;
    x.cnt       = ec;
    x.zero      = (ec == 4'd0);
    x.borrow    = eb;
    x.up_cnt    = exp_up;
    x.up_zero   = (exp_up == 4'd0);
    x.up_borrow = 1'b0;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every cycle for which an expectation is queued.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {count, zero, borrow, up_count, up_zero, up_borrow};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL cycle_check #%0d: got cnt=%0d z=%0b b=%0b up=%0d uz=%0b ub=%0b, want cnt=%0d z=%0b b=%0b up=%0d uz=%0b ub=%0b",
                      n_checks, a.cnt, a.zero, a.borrow, a.up_cnt, a.up_zero, a.up_borrow,
                      e.cnt, e.zero, e.borrow, e.up_cnt, e.up_zero, e.up_borrow);
      end
    end
  end

  initial begin
    logic [3:0] wrapv;
    logic [3:0] c;
    int         budget;

    // Reset held two cycles.
    step(1, 0, 0, 4'd0, 4'd15, 0);
    step(1, 0, 1, 4'd0, 4'd15, 0);

    // Full down-count period with wrap and single-cycle borrow.
    for (int i = 14; i >= 0; i--) step(0, 0, 1, 4'd0, 4'(i), 0);
    step(0, 0, 1, 4'd0, 4'd15, 1);
    step(0, 0, 1, 4'd0, 4'd14, 0);

    // Load wins over en; then decrement from loaded value.
    step(0, 1, 1, 4'd9, 4'd9, 0);
    step(0, 0, 1, 4'd0, 4'd8, 0);
    step(0, 0, 1, 4'd0, 4'd7, 0);

    // Toggled enable from 5.
    step(0, 1, 0, 4'd5, 4'd5, 0);
    step(0, 0, 1, 4'd0, 4'd4, 0);
    step(0, 0, 0, 4'd0, 4'd4, 0);
    step(0, 0, 1, 4'd0, 4'd3, 0);
    step(0, 0, 0, 4'd0, 4'd3, 0);
    step(0, 0, 1, 4'd0, 4'd2, 0);

    // Reset beats coincident load and en.
    step(0, 1, 0, 4'd3, 4'd3, 0);
    step(1, 1, 1, 4'd7, 4'd15, 0);
    step(0, 0, 0, 4'd0, 4'd15, 0);
    step(0, 0, 0, 4'd0, 4'd15, 0);

    // Load 4 then count through underflow: wraps to 15, or to 4 with reload.
    wrapv = RELOAD ? 4'd4 : 4'd15;
    step(0, 1, 0, 4'd4, 4'd4, 0);
    for (int i = 3; i >= 0; i--) step(0, 0, 1, 4'd0, 4'(i), 0);
    step(0, 0, 1, 4'd0, wrapv, 1);
    step(0, 0, 1, 4'd0, wrapv - 4'd1, 0);

    // Load zero then underflow repeatedly; reload of 0 pins count at 0.
    step(0, 1, 0, 4'd0, 4'd0, 0);
    step(0, 0, 1, 4'd0, RELOAD ? 4'd0 : 4'd15, 1);
    step(0, 0, 1, 4'd0, RELOAD ? 4'd0 : 4'd14, RELOAD);
    step(0, 0, 0, 4'd0, RELOAD ? 4'd0 : 4'd14, 0);

    // Load at count zero with en set: load wins, no borrow.
    step(0, 1, 0, 4'd0, 4'd0, 0);
    step(0, 1, 1, 4'd6, 4'd6, 0);

    // Cascade: upper stage steps once per 16 lower cycles.
    step(1, 0, 0, 4'd0, 4'd15, 0);
    for (int k = 1; k <= 33; k++) begin
      c = 4'(15 - k);
      step(0, 0, 1, 4'd0, c, c == 4'd15);
    end
    step(0, 0, 0, 4'd0, 4'd14, 0);

    // Drain the scoreboard with a bounded wait.
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bin_down_counter

// File: doc/bin_down_counter.md
Name: bin_down_counter

Overview:
- WIDTH-bit synchronous binary down counter: the count-down counterpart of the team's 4-bit binary up counter, sharing the same clk/reset interface style.
- Adds count enable, parallel load, zero flag and a one-cycle registered borrow pulse on underflow.
- Used as a programmable divider or timeout source in the behavioural labs; the borrow output can chain into a higher stage's en.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- INIT, 4'b1111 (all ones for WIDTH), value loaded into count on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; decrement by 1 per enabled cycle.
- load  input  1  parallel load strobe.
- din  input  WIDTH  value loaded into count when load=1.
- count  output  WIDTH  current counter value (registered).
- zero  output  1  combinational flag, count == 0.
- borrow  output  1  registered pulse, high for exactly one cycle after an underflow.

Behaviour:
- One clock, clk. Reset is synchronous and active-high: sampled only on rising clk; no asynchronous path.
- Reset values: count = INIT, borrow = 0; zero therefore follows INIT (0 for default).
- Per-edge priority: reset > load > en > hold.
- load=1: count <= din next edge; borrow <= 0; en ignored that cycle (no decrement of din).
- en=1, load=0, count != 0: count <= count - 1; borrow <= 0.
- en=1, load=0, count == 0 (underflow): count <= 2^WIDTH-1 (wrap); borrow <= 1 for that one following cycle only.
- en=0, load=0: count holds; borrow <= 0.
- Latency: count and borrow are valid the cycle after the sampling edge; zero is valid combinationally from count.
- Arithmetic is modulo 2^WIDTH. din is taken verbatim; no saturation.
- Reset asserted mid-count or coincident with load/en: reset wins; count = INIT and borrow = 0 on the next edge.
- Continuous en from INIT=15 gives period 16: 15,14,...,0,15, with borrow high in the cycle count shows 15 after 0.
- No FSM beyond the counter register and borrow flop; no combinational loops.

Optional Feature:
- Macro: DOWNCNT_RELOAD_EN.
- Defined: adds a WIDTH-bit reload register.
  - Reset value of the reload register is INIT. Every load writes din to both count and the reload register.
  - On underflow, count <= reload value instead of 2^WIDTH-1, giving a programmable modulus of reload+1. Borrow timing is unchanged.
  - If the reload value is 0 and en is held, count stays 0 and borrow pulses every enabled cycle.
- Undefined: no reload register; underflow wraps to all ones exactly as above.

Decomposition:
- Shared package dsd_cnt_pkg holds:
  - CNT_WIDTH_DEF = 4.
  - Function cnt_max(width), returning 2^width-1.
  - A typedef for the default-width count value.
- No sub-module; decrement, wrap and borrow logic sit in a single always block plus a zero assign.
- The up counter and this block both import dsd_cnt_pkg.

Test Plan:
- Reset held 2 cycles then released with en=1 -> count 15,14,...,1,0,15; zero=1 only while count=0; borrow=1 only in the cycle count=15 after 0.
- load=1, din=4'd9 with en=1 in the same cycle -> next count=9 (no decrement); then en -> 8,7...
- en toggling 1/0 every cycle from count=5 -> 5,4,4,3,3,2; borrow stays 0.
- reset=1 asserted while count=3 and load=1, din=7 -> next count=15 (INIT), borrow=0.
- Underflow chain: two instances, upper en = lower borrow, both from 15 -> upper decrements once per 16 lower cycles.
- With DOWNCNT_RELOAD_EN: load din=4 then en held -> 4,3,2,1,0,4,3... with borrow each time 4 follows 0; without the macro, same stimulus wraps 0 -> 15.
